// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared FSM state type, width defaults and port-index constants
//   for the two-port round-robin RAM arbiter.
package ram_arb_pkg;
    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;
    typedef logic port_t;
    localparam port_t PORT0 = 1'b0;
    localparam port_t PORT1 = 1'b1;
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;
endpackage

// File: rtl/ram_rr_arbiter_if.sv
// ram_rr_arbiter_if: bundle of both requester channels and the RAM side.
//   req0/1_*  : valid, we, addr, wdata in; ready out (accept pulse)
//   rsp0/1_*  : valid pulse and held read data out; err0/1 error pulse out
//   ram_*     : cs/read/write strobes, address, write data out; read data in
//   modport slave is the arbiter, modport master is requesters plus RAM.
interface ram_rr_arbiter_if #(
    parameter int ADDR_W = ram_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = ram_arb_pkg::DATA_W_DEF
);
    logic              req0_valid, req0_we, req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_valid, req1_we, req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp0_valid, rsp1_valid, err0, err1;
    logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
    logic              ram_cs, ram_read, ram_write;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_write_data, ram_read_data;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  ram_read_data,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp0_rdata, rsp1_rdata, err0, err1,
        output ram_cs, ram_read, ram_write, ram_address, ram_write_data
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output ram_read_data,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp0_rdata, rsp1_rdata, err0, err1,
        input  ram_cs, ram_read, ram_write, ram_address, ram_write_data
    );
endinterface

// File: rtl/rr_grant2.sv
// rr_grant2: two-way round-robin grant.
//   i_req  : request bits, [0]=port 0, [1]=port 1
//   i_last : port granted most recently
//   o_gnt  : winning port index; o_valid : any request present
module rr_grant2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_gnt,
    output logic       o_valid
);
    assign o_valid = |i_req;
    // On a tie the port that did not win last time goes next.
    assign o_gnt   = (&i_req) ? ~i_last : i_req[1];
endmodule

// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: round-robin arbiter and controller giving two requesters
//   access to one synchronous-read RAM (IDLE -> ACCESS [-> CAPTURE] -> IDLE).
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : ram_rr_arbiter_if.slave (requester channels and RAM side)
//   Build option RAM_ARB_RO1_EN: port 1 becomes read-only; its writes are
//   accepted, perform no access and raise err1 in the following cycle.
module ram_rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic               clk,
    input logic               rst,
    ram_rr_arbiter_if.slave   bus
);
    state_t            r_state, w_state_nxt;
    port_t             r_last, r_port;
    logic              r_we, r_rsp0, r_rsp1, r_err1;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata0, r_rdata1;
    logic              w_gnt, w_any, w_accept, w_acc, w_ro_err, w_req_we;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_wdata;

    rr_grant2 u_grant (
        .i_req   ({bus.req1_valid, bus.req0_valid}),
        .i_last  (r_last),
        .o_gnt   (w_gnt),
        .o_valid (w_any)
    );

    assign w_req_we    = w_gnt ? bus.req1_we    : bus.req0_we;
    assign w_req_addr  = w_gnt ? bus.req1_addr  : bus.req0_addr;
    assign w_req_wdata = w_gnt ? bus.req1_wdata : bus.req0_wdata;
    // Reset wins over any pending request in the same cycle.
    assign w_accept    = (r_state == IDLE) && w_any && !rst;
`ifdef RAM_ARB_RO1_EN
    assign w_ro_err    = (w_gnt == PORT1) && w_req_we;
`else
    assign w_ro_err    = 1'b0;
`endif
    // An accept that actually starts a RAM access.
    assign w_acc       = w_accept && !w_ro_err;

    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    w_state_nxt = w_acc ? ACCESS : IDLE;
            ACCESS:  w_state_nxt = r_we ? IDLE : CAPTURE;
            CAPTURE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last   <= PORT1;
            r_port   <= PORT0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_rsp0   <= 1'b0;
            r_rsp1   <= 1'b0;
            r_err1   <= 1'b0;
        end else begin
            r_rsp0 <= (r_state == CAPTURE) && (r_port == PORT0);
            r_rsp1 <= (r_state == CAPTURE) && (r_port == PORT1);
            r_err1 <= w_accept && w_ro_err;
            if (w_accept) r_last <= w_gnt;
            if (w_acc) begin
                r_port <= w_gnt;
                r_we   <= w_req_we;
                r_addr <= w_req_addr;
            end
            // Write data only moves for writes so reads leave it untouched.
            if (w_acc && w_req_we) r_wdata <= w_req_wdata;
            if (r_state == CAPTURE && r_port == PORT0) r_rdata0 <= bus.ram_read_data;
            if (r_state == CAPTURE && r_port == PORT1) r_rdata1 <= bus.ram_read_data;
        end
    end

    assign bus.req0_ready     = w_accept && (w_gnt == PORT0);
    assign bus.req1_ready     = w_accept && (w_gnt == PORT1);
    assign bus.rsp0_valid     = r_rsp0;
    assign bus.rsp1_valid     = r_rsp1;
    assign bus.rsp0_rdata     = r_rdata0;
    assign bus.rsp1_rdata     = r_rdata1;
    assign bus.err0           = 1'b0;
    assign bus.err1           = r_err1;
    assign bus.ram_cs         = (r_state == ACCESS);
    assign bus.ram_read       = (r_state == ACCESS) && !r_we;
    assign bus.ram_write      = (r_state == ACCESS) && r_we;
    assign bus.ram_address    = r_addr;
    assign bus.ram_write_data = r_wdata;
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb_ram_rr_arbiter: directed self-checking bench for ram_rr_arbiter with a
//   synchronous-read RAM model preloaded with mem[i] = 0x40 + i.
module tb_ram_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_init = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;
    int         n_wr = 0;
    int         w0;
    logic [7:0] mem [128];
    logic [6:0] a0, a1;
    logic [7:0] d0, d1;
    logic       g;

    ram_rr_arbiter_if bus ();

    ram_rr_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'(8'h40 + i);
            mem_init <= 1'b1;
        end else begin
            if (bus.ram_cs && bus.ram_write) begin
                mem[bus.ram_address] <= bus.ram_write_data;
                n_wr <= n_wr + 1;
            end
            if (bus.ram_cs && bus.ram_read) bus.ram_read_data <= mem[bus.ram_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set0(input logic v, input logic we, input logic [6:0] a, input logic [7:0] d);
        bus.req0_valid = v;
        bus.req0_we    = we;
        bus.req0_addr  = a;
        bus.req0_wdata = d;
    endtask

    task automatic set1(input logic v, input logic we, input logic [6:0] a, input logic [7:0] d);
        bus.req1_valid = v;
        bus.req1_we    = we;
        bus.req1_addr  = a;
        bus.req1_wdata = d;
    endtask

    initial begin
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        tick; tick; tick;
        // reset values, with a request pending under reset
        set0(1, 1, 7'h01, 8'h03);
        #1;
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        chk("rst_rsp0_valid", bus.rsp0_valid, 0);
        chk("rst_rsp1_valid", bus.rsp1_valid, 0);
        chk("rst_err0", bus.err0, 0);
        chk("rst_err1", bus.err1, 0);
        chk("rst_cs", bus.ram_cs, 0);
        chk("rst_read", bus.ram_read, 0);
        chk("rst_write", bus.ram_write, 0);
        chk("rst_addr", bus.ram_address, 0);
        chk("rst_wdata", bus.ram_write_data, 0);
        chk("rst_rdata0", bus.rsp0_rdata, 0);
        chk("rst_rdata1", bus.rsp1_rdata, 0);

        // port 0 write 0x03 to 0x01, then read it back
        tick; rst = 1'b0; #1;
        chk("t1_ready0_w", bus.req0_ready, 1);
        chk("t1_ready1_w", bus.req1_ready, 0);
        tick; set0(1, 0, 7'h01, 8'h00); #1;
        chk("t1_acc_cs", bus.ram_cs, 1);
        chk("t1_acc_write", bus.ram_write, 1);
        chk("t1_acc_read", bus.ram_read, 0);
        chk("t1_acc_addr", bus.ram_address, 7'h01);
        chk("t1_acc_wdata", bus.ram_write_data, 8'h03);
        chk("t1_acc_noready", bus.req0_ready, 0);
        tick; #1;
        chk("t1_ready0_r", bus.req0_ready, 1);
        chk("t1_idle_cs", bus.ram_cs, 0);
        chk("t1_one_write", n_wr, 1);
        tick; set0(0, 0, 0, 0); #1;
        chk("t1_acc_rd", bus.ram_read, 1);
        chk("t1_acc_rd_addr", bus.ram_address, 7'h01);
        tick; #1;
        chk("t1_cap_cs", bus.ram_cs, 0);
        chk("t1_cap_rsp0", bus.rsp0_valid, 0);
        tick; #1;
        chk("t1_rsp0_valid", bus.rsp0_valid, 1);
        chk("t1_rsp0_rdata", bus.rsp0_rdata, 8'h03);
        tick; #1;
        chk("t1_rsp0_pulse", bus.rsp0_valid, 0);
        chk("t1_rsp0_hold", bus.rsp0_rdata, 8'h03);

        // both ports valid out of reset: port 0 reads 0x07, port 1 reads 0x03
        tick; rst = 1'b1; set0(1, 0, 7'h07, 0); set1(1, 0, 7'h03, 0);
        tick; #1;
        chk("t2_rst_prio0", bus.req0_ready, 0);
        chk("t2_rst_prio1", bus.req1_ready, 0);
        tick; rst = 1'b0; #1;
        chk("t2_first0", bus.req0_ready, 1);
        chk("t2_first1", bus.req1_ready, 0);
        tick; set0(0, 0, 0, 0); #1;
        chk("t2_acc_read", bus.ram_read, 1);
        chk("t2_acc_addr", bus.ram_address, 7'h07);
        chk("t2_acc_noready1", bus.req1_ready, 0);
        tick; #1;
        chk("t2_cap_noready1", bus.req1_ready, 0);
        tick; #1;
        chk("t2_rsp0_valid", bus.rsp0_valid, 1);
        chk("t2_rsp0_rdata", bus.rsp0_rdata, 8'h47);
        chk("t2_second1", bus.req1_ready, 1);
        chk("t2_rsp1_quiet", bus.rsp1_valid, 0);
        tick; set1(0, 0, 0, 0); #1;
        chk("t2_acc1_addr", bus.ram_address, 7'h03);
        chk("t2_rsp0_pulse", bus.rsp0_valid, 0);
        tick; tick; #1;
        chk("t2_rsp1_valid", bus.rsp1_valid, 1);
        chk("t2_rsp1_rdata", bus.rsp1_rdata, 8'h43);
        chk("t2_rsp0_kept", bus.rsp0_rdata, 8'h47);
        chk("t2_no_overlap", bus.rsp0_valid, 0);

`ifndef RAM_ARB_RO1_EN
        // six back-to-back writes with both ports always valid
        a0 = 7'h10; d0 = 8'h80; a1 = 7'h20; d1 = 8'h90;
        tick; set0(1, 1, a0, d0); set1(1, 1, a1, d1);
        for (int i = 0; i < 6; i++) begin
            g = 1'(i % 2);
            #1;
            chk("t3_grant0", bus.req0_ready, {31'd0, !g});
            chk("t3_grant1", bus.req1_ready, {31'd0, g});
            tick; #1;
            chk("t3_acc_write", bus.ram_write, 1);
            chk("t3_acc_addr", bus.ram_address, g ? a1 : a0);
            chk("t3_acc_wdata", bus.ram_write_data, g ? d1 : d0);
            chk("t3_acc_noready", bus.req0_ready | bus.req1_ready, 0);
            if (g) begin a1++; d1++; set1(1, 1, a1, d1); end
            else begin a0++; d0++; set0(1, 1, a0, d0); end
            tick;
        end
        set0(0, 0, 0, 0); set1(0, 0, 0, 0); #1;
        chk("t3_write_count", n_wr, 7);
`endif

        // reset during CAPTURE of a port 1 read
        tick; set1(1, 0, 7'h03, 0); #1;
        chk("t4_ready1", bus.req1_ready, 1);
        tick; set1(0, 0, 0, 0); #1;
        chk("t4_acc_read", bus.ram_read, 1);
        tick; rst = 1'b1; #1;
        chk("t4_cap_cs", bus.ram_cs, 0);
        tick; rst = 1'b0; #1;
        chk("t4_no_rsp1", bus.rsp1_valid, 0);
        chk("t4_cs", bus.ram_cs, 0);
        chk("t4_read", bus.ram_read, 0);
        chk("t4_addr", bus.ram_address, 0);
        chk("t4_wdata", bus.ram_write_data, 0);
        chk("t4_rdata0", bus.rsp0_rdata, 0);
        chk("t4_rdata1", bus.rsp1_rdata, 0);
        tick; #1;
        chk("t4_no_late_rsp1", bus.rsp1_valid, 0);

        // port 1 write 0x86 to 0x03, then port 0 reads 0x03
        w0 = n_wr;
        tick; set1(1, 1, 7'h03, 8'h86); #1;
        chk("t5_ready1", bus.req1_ready, 1);
        tick; set1(0, 0, 0, 0); set0(1, 0, 7'h03, 0); #1;
        chk("t5_err0", bus.err0, 0);
`ifdef RAM_ARB_RO1_EN
        chk("t5_err1", bus.err1, 1);
        chk("t5_no_cs", bus.ram_cs, 0);
        chk("t5_ready0", bus.req0_ready, 1);
        tick; set0(0, 0, 0, 0); #1;
        chk("t5_err1_pulse", bus.err1, 0);
        chk("t5_acc_read", bus.ram_read, 1);
        chk("t5_no_write", n_wr, w0);
        tick; tick; #1;
        chk("t5_rsp0_valid", bus.rsp0_valid, 1);
        chk("t5_old_value", bus.rsp0_rdata, 8'h43);
`else
        chk("t5_err1", bus.err1, 0);
        chk("t5_write", bus.ram_write, 1);
        chk("t5_addr", bus.ram_address, 7'h03);
        chk("t5_wdata", bus.ram_write_data, 8'h86);
        tick; #1;
        chk("t5_ready0", bus.req0_ready, 1);
        chk("t5_one_write", n_wr, w0 + 1);
        tick; set0(0, 0, 0, 0); #1;
        chk("t5_acc_read", bus.ram_read, 1);
        tick; tick; #1;
        chk("t5_rsp0_valid", bus.rsp0_valid, 1);
        chk("t5_new_value", bus.rsp0_rdata, 8'h86);
        chk("t5_err1_idle", bus.err1, 0);
`endif
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ram_rr_arbiter.md
RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, RAM address width (128 words).
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have one clock and synchronous active-high reset: clk input 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have, for each requester n in {0,1}: reqn_valid input 1, request pending; reqn_we input 1, 1=write 0=read; reqn_addr input ADDR_W; reqn_wdata input DATA_W.
REQ-006 SHALL have reqn_ready output 1, one-cycle accept pulse; rspn_valid output 1, one-cycle read-data pulse; rspn_rdata output DATA_W; errn output 1, one-cycle error pulse.
REQ-007 SHALL drive the RAM side: ram_cs output 1; ram_read output 1; ram_write output 1; ram_address output ADDR_W; ram_write_data output DATA_W; ram_read_data input DATA_W.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, CAPTURE.
REQ-009 SHALL accept at most one request per IDLE cycle: ready to the granted port only, combinational in that cycle; addr/we/wdata/port latched at the clock edge.
REQ-010 SHALL arbitrate round-robin: single requester wins; with both valid, the port not granted last wins; last-grant pointer updates on each accept.
REQ-011 SHALL, in ACCESS (one cycle), assert ram_cs=1 with exactly one of ram_read/ram_write per latched we, address/data from the latched request.
REQ-012 SHALL go from ACCESS to IDLE for writes (accept-to-next-accept 2 cycles) and from ACCESS to CAPTURE for reads.
REQ-013 SHALL, in CAPTURE, register ram_read_data into the owning port's rspn_rdata and pulse rspn_valid in the following cycle (3 cycles after the accept cycle); the FSM returns to IDLE in that same cycle.
REQ-014 SHALL hold rspn_rdata until that port's next read response; the other port's rdata is unaffected.
REQ-015 SHALL keep ram_cs/ram_read/ram_write at 0 in IDLE and CAPTURE; ram_address/ram_write_data hold their last value.
REQ-016 SHALL never assert reqn_ready outside IDLE; requesters hold valid and payload until ready.
REQ-017 SHALL treat a valid deasserted before ready as withdrawn, with no access.

Reset
REQ-018 SHALL on rst: state=IDLE; last-grant pointer=1 (port 0 wins the first tie); all ready/valid/err/ram strobes=0; rspn_rdata=0; ram_address=0; ram_write_data=0.
REQ-019 SHALL abort an in-flight access on rst in ACCESS or CAPTURE: strobes 0 from the next cycle, no rspn_valid for the aborted read.
REQ-020 SHALL give rst priority over simultaneous valid requests (no ready that cycle).

Configuration
REQ-021 With RAM_ARB_RO1_EN defined, port 1 SHALL be read-only: a port 1 write is accepted (ready pulses), no RAM access occurs, err1 pulses the next cycle, FSM stays IDLE.
REQ-022 Without RAM_ARB_RO1_EN, port 1 writes behave as port 0 writes; err0/err1 are tied 0 in both builds except err1 as above.

Structure
REQ-023 SHALL place the FSM state enum, ADDR_W/DATA_W defaults and the port-index constant in shared package ram_arb_pkg.
REQ-024 SHALL contain the RAM controller FSM and arbiter in one module; the RAM itself is instantiated outside the block.
REQ-025 MAY split the grant logic into sub-module rr_grant2 (2-way round-robin, pointer in, grant out).

Verification
REQ-026 Port 0 write addr 0x01 data 0x03, then read 0x01 -> ram_write pulse 1 cycle; rsp0_valid 3 cycles after the read accept, rsp0_rdata=0x03.
REQ-027 Both ports valid from reset: port 0 read 0x07, port 1 read 0x03 -> port 0 granted first, then port 1; rsp0 and rsp1 carry the correct data, no overlap.
REQ-028 Both ports continuously valid for 6 writes -> grants alternate 0,1,0,1,0,1; an accept every 2 cycles.
REQ-029 rst asserted in CAPTURE of a port 1 read -> no rsp1_valid; all outputs at reset values the next cycle.
REQ-030 RAM_ARB_RO1_EN build: port 1 write 0x86 to 0x03 -> ready1 pulse, err1 pulse next cycle, no ram_write; a port 0 read of 0x03 returns the old value.
